// File: rtl/mul_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one external pipelined
// 16x16 multiplier. Each requester owns a small response FIFO; issue is
// throttled by per-requester credits so a returning product always finds room.
module mul_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MUL_LAT   = 5,
    parameter int RSP_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [16*N_REQ-1:0]  req_a,
    input  logic [16*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [32*N_REQ-1:0]  rsp_data,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic                 mul_rst_n,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    input  logic [31:0]          mul_y,
    output logic                 busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic             grant_any;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] issue;
    logic [N_REQ-1:0] credit_nz;
    logic [N_REQ-1:0] fifo_nempty;
    logic [15:0]      sel_a;
    logic [15:0]      sel_b;
    logic [15:0]      mul_a_q;
    logic [15:0]      mul_b_q;

    // Tag pipeline tracks which requester owns the product currently in the
    // multiplier; stage MUL_LAT lines up with mul_y for the issuing operands.
    logic [MUL_LAT:0] tag_v;
    logic [IDX_W-1:0] tag_idx [MUL_LAT+1];

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = (int'(base) + off) % N_REQ;
        return IDX_W'(sum);
    endfunction

    // Eligibility uses only registered credits, so req_ready never sees rsp_ready.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] && credit_nz[i] && !rst;
        end
    end

    // Round-robin pick starting one past the last granted requester.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = rr_next(last_grant, off);
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // One-hot ready; a ready bit is only raised for a valid requester, so it is the handshake.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = grant_any && (grant_idx == IDX_W'(i));
        end
    end

    assign issue = req_ready;

    // Operand mux; idle cycles feed zeros to the multiplier.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (issue[i]) begin
                sel_a = req_a[16*i +: 16];
                sel_b = req_b[16*i +: 16];
            end
        end
    end

    // Operand registers, arbitration pointer and tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            last_grant <= LAST_IDX;
            tag_v      <= '0;
            for (int j = 0; j <= MUL_LAT; j++) begin
                tag_idx[j] <= '0;
            end
        end else begin
            mul_a_q    <= sel_a;
            mul_b_q    <= sel_b;
            if (grant_any) begin
                last_grant <= grant_idx;
            end
            tag_v[0]   <= grant_any;
            tag_idx[0] <= grant_idx;
            for (int j = 1; j <= MUL_LAT; j++) begin
                tag_v[j]   <= tag_v[j-1];
                tag_idx[j] <= tag_idx[j-1];
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_rsp
        logic [31:0]      mem [RSP_DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] credit;
        logic             push;
        logic             pop;

        function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
            return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
        endfunction

        assign push           = tag_v[MUL_LAT] && (tag_idx[MUL_LAT] == IDX_W'(g));
        assign pop            = fifo_nempty[g] && rsp_ready[g];
        assign fifo_nempty[g] = (cnt != '0);
        assign credit_nz[g]   = (credit != '0);
        assign rsp_valid[g]   = fifo_nempty[g] && !rst;
        assign rsp_data[32*g +: 32] = rsp_valid[g] ? mem[rd_ptr] : '0;

        // Response FIFO plus credit counter; credits cover in-flight and buffered results.
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                credit <= DEPTH_C;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= mul_y;
                    wr_ptr      <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                case ({push, pop})
                    2'b10:   cnt <= cnt + CNT_W'(1);
                    2'b01:   cnt <= cnt - CNT_W'(1);
                    default: cnt <= cnt;
                endcase
                case ({issue[g], pop})
                    2'b10:   credit <= credit - CNT_W'(1);
                    2'b01:   credit <= credit + CNT_W'(1);
                    default: credit <= credit;
                endcase
            end
        end
    end

    assign mul_rst_n = ~rst;
    assign mul_a     = rst ? '0 : mul_a_q;
    assign mul_b     = rst ? '0 : mul_b_q;
    assign busy      = !rst && ((|tag_v) || (|fifo_nempty));

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: a pipelined multiplier model drives mul_y, and a
// queue-based model of issued operations predicts grants, response timing,
// data and busy every cycle.
module tb_mul_arbiter;

    localparam int N   = 4;
    localparam int LAT = 5;
    localparam int DEP = 4;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [16*N-1:0]   req_a;
    logic [16*N-1:0]   req_b;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [32*N-1:0]   rsp_data;
    logic [N-1:0]      rsp_ready;
    logic              mul_rst_n;
    logic [15:0]       mul_a;
    logic [15:0]       mul_b;
    logic [31:0]       mul_y;
    logic              busy;

    mul_arbiter #(.N_REQ(N), .MUL_LAT(LAT), .RSP_DEPTH(DEP)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .mul_rst_n(mul_rst_n), .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External multiplier: product appears LAT edges after operands change.
    logic [31:0] mpipe [LAT];
    always @(posedge clk) begin
        if (!mul_rst_n) begin
            for (int j = 0; j < LAT; j++) mpipe[j] <= '0;
        end else begin
            mpipe[0] <= 32'(mul_a) * 32'(mul_b);
            for (int j = 1; j < LAT; j++) mpipe[j] <= mpipe[j-1];
        end
    end
    assign mul_y = mpipe[LAT-1];

    typedef struct {
        int          idx;
        int          t;
        logic [31:0] d;
    } ent_t;

    ent_t        pend[$];
    int          now;
    int          last_g;
    logic [15:0] exp_a, exp_b;
    int          n_tests, n_fail;
    int          hs_cnt [N];
    logic [N-1:0] obs_ready;
    logic        saw_rsp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, now, obs, expv);
        end
    endtask

    // Predict this cycle's outputs from the issue history, then commit the coming edge.
    task automatic model_step();
        int          cnt [N];
        int          head [N];
        logic [N-1:0] elig, exp_rdy, exp_rv;
        int          g, c, i;
        logic [15:0] a, b;
        ent_t        e;
        for (int k = 0; k < N; k++) begin
            cnt[k]  = 0;
            head[k] = -1;
        end
        for (int k = 0; k < pend.size(); k++) begin
            i = pend[k].idx;
            if (head[i] < 0) head[i] = k;
            cnt[i]++;
        end
        obs_ready = req_ready;
        if (rst) begin
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_rsp_data_lo", rsp_data[63:0], 64'd0);
            chk("rst_rsp_data_hi", rsp_data[127:64], 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_mul_rst_n", 64'(mul_rst_n), 64'd0);
            chk("rst_mul_ab", 64'({mul_a, mul_b}), 64'd0);
            pend.delete();
            last_g = N - 1;
            exp_a  = '0;
            exp_b  = '0;
            return;
        end
        elig    = '0;
        exp_rdy = '0;
        exp_rv  = '0;
        for (int k = 0; k < N; k++) begin
            elig[k]   = req_valid[k] && (cnt[k] < DEP);
            exp_rv[k] = (head[k] >= 0) && (pend[head[k]].t <= now);
        end
        g = -1;
        for (int off = 1; off <= N; off++) begin
            c = (last_g + off) % N;
            if (g < 0 && elig[c]) g = c;
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        chk("busy", 64'(busy), 64'(pend.size() > 0));
        chk("mul_ab", 64'({mul_a, mul_b}), 64'({exp_a, exp_b}));
        chk("mul_rst_n", 64'(mul_rst_n), 64'd1);
        for (int k = 0; k < N; k++) begin
            if (exp_rv[k]) chk("rsp_data", 64'(rsp_data[32*k +: 32]), 64'(pend[head[k]].d));
            if (req_ready[k] && req_valid[k]) hs_cnt[k]++;
        end
        if (|rsp_valid) saw_rsp = 1'b1;
        for (int k = pend.size() - 1; k >= 0; k--) begin
            i = pend[k].idx;
            if (k == head[i] && exp_rv[i] && rsp_ready[i]) pend.delete(k);
        end
        if (g >= 0) begin
            a     = req_a[16*g +: 16];
            b     = req_b[16*g +: 16];
            e.idx = g;
            e.t   = now + LAT + 2;
            e.d   = 32'(a) * 32'(b);
            pend.push_back(e);
            last_g = g;
            exp_a  = a;
            exp_b  = b;
        end else begin
            exp_a = '0;
            exp_b = '0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        now++;
        #1;
    endtask

    task automatic clr_hs();
        for (int k = 0; k < N; k++) hs_cnt[k] = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        cycle();
        cycle();
        rst = 1'b0;
        clr_hs();
    endtask

    task automatic rand_ops();
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
    endtask

    initial begin
        int cnt;
        n_tests   = 0;
        n_fail    = 0;
        now       = 0;
        last_g    = N - 1;
        exp_a     = '0;
        exp_b     = '0;
        saw_rsp   = 1'b0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;
        clr_hs();

        // Reset holds all outputs low even with requests pending.
        req_valid = '1;
        cycle();
        cycle();
        do_reset();

        // Single operation latency and busy drop.
        rsp_ready = '1;
        req_valid = 4'b0001;
        req_a[15:0] = 16'h0003;
        req_b[15:0] = 16'h0005;
        cycle();
        req_valid = '0;
        cnt = 0;
        while (!rsp_valid[0] && cnt < 20) begin
            cycle();
            cnt++;
        end
        chk("lat_cycles", 64'(cnt), 64'd6);
        chk("lat_data", 64'(rsp_data[31:0]), 64'h0000000F);
        cycle();
        chk("lat_busy_low", 64'(busy), 64'd0);

        // All requesters valid: rotation 0,1,2,3,0,1.
        do_reset();
        rsp_ready = '1;
        req_valid = '1;
        for (int c = 0; c < 6; c++) begin
            rand_ops();
            cycle();
            chk("rr_grant", 64'(obs_ready), 64'(1) << (c % 4));
        end
        req_valid = '0;
        for (int c = 0; c < 12; c++) cycle();

        // Requester 2 stalls its responses: credit exhaustion then one pop.
        do_reset();
        req_valid = '1;
        rsp_ready = 4'b1011;
        for (int c = 0; c < 16; c++) begin
            rand_ops();
            cycle();
        end
        chk("stall_hs", 64'(hs_cnt[2]), 64'd4);
        chk("stall_r2_blocked", 64'(obs_ready[2]), 64'd0);
        chk("stall_others", 64'(obs_ready != 0), 64'd1);
        rsp_ready = 4'b1111;
        cycle();
        rsp_ready = 4'b1011;
        for (int c = 0; c < 12; c++) begin
            rand_ops();
            cycle();
        end
        chk("stall_hs_after_pop", 64'(hs_cnt[2]), 64'd5);
        req_valid = '0;
        rsp_ready = '1;
        for (int c = 0; c < 14; c++) cycle();

        // Back-to-back max and zero products for requester 1.
        do_reset();
        rsp_ready = '1;
        req_valid = 4'b0010;
        req_a[31:16] = 16'hFFFF;
        req_b[31:16] = 16'hFFFF;
        cycle();
        req_a[31:16] = 16'h0000;
        req_b[31:16] = 16'h1234;
        cycle();
        req_valid = '0;
        chk("b2b_hs", 64'(hs_cnt[1]), 64'd2);
        cnt = 0;
        while (!rsp_valid[1] && cnt < 20) begin
            cycle();
            cnt++;
        end
        chk("b2b_v0", 64'(rsp_valid[1]), 64'd1);
        chk("b2b_d0", 64'(rsp_data[63:32]), 64'hFFFE0001);
        cycle();
        chk("b2b_v1", 64'(rsp_valid[1]), 64'd1);
        chk("b2b_d1", 64'(rsp_data[63:32]), 64'h00000000);
        cycle();

        // Reset with operations in flight.
        do_reset();
        rsp_ready = '1;
        req_valid = '1;
        for (int c = 0; c < 3; c++) begin
            rand_ops();
            cycle();
        end
        rst = 1'b1;
        cycle();
        chk("midrst_ready", 64'(req_ready), 64'd0);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        rst       = 1'b0;
        req_valid = '0;
        saw_rsp   = 1'b0;
        for (int c = 0; c < 12; c++) cycle();
        chk("midrst_no_rsp", 64'(saw_rsp), 64'd0);
        req_valid = '1;
        cycle();
        chk("midrst_first_grant", 64'(obs_ready), 64'd1);
        clr_hs();
        req_valid = 4'b1000;
        rsp_ready = 4'b0111;
        for (int c = 0; c < 10; c++) cycle();
        chk("midrst_full_credit", 64'(hs_cnt[3]), 64'd4);
        req_valid = '0;
        rsp_ready = '1;
        for (int c = 0; c < 12; c++) cycle();

        // Issue and pop together at credit 1.
        do_reset();
        rsp_ready = '0;
        req_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            rand_ops();
            cycle();
        end
        req_valid = '0;
        for (int c = 0; c < 8; c++) cycle();
        req_valid = 4'b0001;
        rsp_ready = 4'b0001;
        rand_ops();
        cycle();
        chk("cr1_issue", 64'(obs_ready[0]), 64'd1);
        rsp_ready = '0;
        for (int c = 0; c < 10; c++) begin
            rand_ops();
            cycle();
        end
        chk("cr1_hs_total", 64'(hs_cnt[0]), 64'd5);
        req_valid = '0;
        rsp_ready = '1;
        for (int c = 0; c < 12; c++) cycle();
        chk("cr1_drained", 64'(busy), 64'd0);

        // Randomized traffic with occasional reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rand_ops();
            if ($urandom_range(15) == 0) req_a[16*$urandom_range(N-1) +: 16] = 16'hFFFF;
            req_valid = 4'($urandom);
            rsp_ready = 4'($urandom) | 4'($urandom);
            rst       = ($urandom_range(399) == 0);
            cycle();
        end
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        for (int c = 0; c < 20; c++) cycle();
        chk("final_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
